// File: rtl/cpu_step_controller_if.sv
// Signal bundle between the step controller and the board/CPU side: raw operator
// inputs and the current PC come in, the advance strobe and debug status go out.
interface cpu_step_controller_if #(
    parameter int PC_W = 32
);
    logic            step_btn_n;
    logic            run_sw;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc;
    logic            cpu_step;
    logic            halted;
    logic [1:0]      mode;
    logic [31:0]     step_count;

    // cpu_step is a one-cycle strobe with no ready: the CPU advances exactly once
    // per cycle it is high. pc is expected to change only after such a strobe.
    modport master (
        output step_btn_n, run_sw, bp_en, bp_addr, pc,
        input  cpu_step, halted, mode, step_count
    );

    modport slave (
        input  step_btn_n, run_sw, bp_en, bp_addr, pc,
        output cpu_step, halted, mode, step_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// CPU advance-pulse generator: debounced single-step button, divided free-run,
// and halt-on-breakpoint with press-to-continue.

module cpu_step_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Counter tracks how long the synced level has disagreed with the accepted one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000,
    parameter int PC_W            = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_step_controller_if.slave bus
);
    localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic          btn_level;
    logic          btn_level_q;
    logic          run_level;
    logic          press;
    logic          bp_hit;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic          step_nxt;
    logic          step_q;
    logic          halted_q;
    logic [31:0]   count_q;

    // Button is inverted before synchronizing so reset-cleared flops mean "released".
    cpu_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk   (clk),
        .reset (reset),
        .raw   (~bus.step_btn_n),
        .level (btn_level)
    );

    cpu_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.run_sw),
        .level (run_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level_q <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
        end
    end

    assign press  = btn_level & ~btn_level_q;
    assign bp_hit = bus.bp_en && (PC_W'(bus.pc) == PC_W'(bus.bp_addr));

    // A low run switch outranks terminal count, breakpoint and press alike.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        step_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press) begin
                    step_nxt = 1'b1;
                end
                if (run_level) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (!run_level) begin
                    state_nxt = ST_IDLE;
                    div_nxt   = '0;
                end else if (div == DW'(RUN_DIV - 1)) begin
                    div_nxt = '0;
                    if (bp_hit) begin
                        state_nxt = ST_HALT;
                    end else begin
                        step_nxt = 1'b1;
                    end
                end else begin
                    div_nxt = div + DW'(1);
                end
            end
            ST_HALT: begin
                if (!run_level) begin
                    state_nxt = ST_IDLE;
                    div_nxt   = '0;
                end else if (press) begin
                    step_nxt  = 1'b1;
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            div      <= '0;
            step_q   <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            step_q   <= step_nxt;
            halted_q <= (state_nxt == ST_HALT);
            count_q  <= count_q + {31'd0, step_nxt};
        end
    end

    // The state register doubles as the exported mode so debug views see it directly.
    assign bus.cpu_step   = step_q;
    assign bus.halted     = halted_q;
    assign bus.mode       = state;
    assign bus.step_count = count_q;
endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Sits directly upstream of the single-cycle CPU top and generates the CPU advance pulse.
- Debounces the raw step button and the run switch, and provides three modes: manual single-step, free-run at a divided rate, and halt on a PC breakpoint.
- Consumes the CPU's current PC for breakpoint comparison. Exports mode, halt and step-count status for the 7-segment and VGA debug paths.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new input level (10 ms at 50 MHz)
RUN_DIV, 5000000, clk cycles between steps in RUN mode (10 Hz at 50 MHz)
PC_W, 32, width of pc and bp_addr

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
step_btn_n  in  1  raw step push-button, active-low, asynchronous to clk
run_sw  in  1  raw run switch, high = run, asynchronous to clk
bp_en  in  1  breakpoint enable (treated as quasi-static)
bp_addr  in  PC_W  breakpoint PC
pc  in  PC_W  current CPU PC
cpu_step  out  1  one-clk-wide advance pulse to the CPU
halted  out  1  high while in BP_HALT
mode  out  2  00 IDLE, 01 RUN, 10 BP_HALT
step_count  out  32  total cpu_step pulses issued

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, mode = IDLE.
  - Synchronizers, debounce counters, divider and step_count cleared.
  - Debounced button = released; debounced switch = low.
  - Reset mid-run or mid-pulse drops cpu_step in the same cycle.
- Input path:
  - Each raw input passes through a 2-FF synchronizer, then a debouncer.
  - Debouncer: a counter runs while the synced level differs from the stable level, and clears on any match.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes the new level.
- Press event: a single-cycle strobe on the stable released-to-pressed transition. Release generates nothing.
- Output timing: cpu_step and all outputs are registered. cpu_step is high for exactly 1 cycle per step.
- IDLE:
  - Press event -> cpu_step the next cycle. The breakpoint is ignored for manual steps.
  - Stable run_sw = 1 -> RUN with divider = 0.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - At terminal count: if bp_en and pc == bp_addr, go to BP_HALT and issue no pulse; otherwise pulse cpu_step.
  - Press events are ignored.
- BP_HALT:
  - halted = 1.
  - Press event -> one cpu_step, then back to RUN with divider = 0 (continue past the breakpoint).
- Priority: stable run_sw = 0 in RUN or BP_HALT -> IDLE next cycle and clear the divider. This beats a terminal count, the breakpoint and a press event in the same cycle.
- step_count: +1 on every cpu_step. Wraps 0xFFFFFFFF -> 0.
- Breakpoint comparison is full-width equality on PC_W bits and is combinational on pc. pc changes only after a cpu_step.
- Loop on the breakpoint PC: if PC returns to bp_addr, the next terminal count halts again (intended).

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, RUN_DIV=8. PC model adds 4 per cpu_step, starting at 0.)
1. Bounce: step_btn_n toggles every 2 cycles for 12 cycles, then held low for 20 cycles -> exactly one cpu_step pulse, 1 cycle wide; step_count=1.
2. Glitch: step_btn_n low for 3 cycles, then high -> no cpu_step; step_count=0.
3. Run: run_sw held high for 200 cycles, bp_en=0 ->
   - mode=01;
   - consecutive cpu_step pulses exactly 8 cycles apart;
   - dropping run_sw -> mode=00 within 4+3 cycles and no further pulses.
4. Breakpoint: bp_en=1, bp_addr=0x10, run_sw high ->
   - 4 pulses (pc=0x10);
   - next terminal count gives no pulse, halted=1, mode=10, step_count=4;
   - a press gives one pulse (pc=0x14) and mode=01.
5. Priority: in BP_HALT, release run_sw and press the button in the same debounced cycle -> mode=00, halted=0, no cpu_step.
6. Reset mid-run: assert reset during the cpu_step cycle with step_count=7 -> cpu_step=0, step_count=0, mode=00 immediately (asynchronously); after release, stays IDLE until run_sw has been re-debounced.
